// File: rtl/exec_muldiv_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer:
// operation codes, FSM state encodings and a small decode helper.
package exec_muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One iteration of the iterative multiply/divide engine, purely combinational.
// Ports: acc (2*DATA_W+1 partial state), opnd (multiplicand / divisor magnitude),
//        div_mode (1 = restoring divide step, 0 = shift-add step), acc_next.
// Mult layout: acc = {carry, product_hi, multiplier/product_lo}, shifts right.
// Div layout:  acc = {remainder (DATA_W+1), dividend/quotient}, shifts left.
module muldiv_iter_core #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W:0] acc,
    input  logic [DATA_W-1:0] opnd,
    input  logic              div_mode,
    output logic [2*DATA_W:0] acc_next
);

    logic [DATA_W:0]   sum;
    logic [2*DATA_W:0] added;
    logic [2*DATA_W:0] shl;
    logic [DATA_W+1:0] diff;

    always_comb begin
        sum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, opnd};
        added = acc[0] ? {sum, acc[DATA_W-1:0]} : acc;
        shl   = {acc[2*DATA_W-1:0], 1'b0};
        // Extra top bit of diff is the borrow of the trial subtract.
        diff  = {1'b0, shl[2*DATA_W:DATA_W]} - {2'b00, opnd};
        if (div_mode) begin
            if (diff[DATA_W+1]) begin
                acc_next = shl;
            end else begin
                acc_next = {diff[DATA_W:0], shl[DATA_W-1:1], 1'b1};
            end
        end else begin
            acc_next = {1'b0, added[2*DATA_W:1]};
        end
    end

endmodule

// File: rtl/exec_muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: iterative MULT/DIV engine, HI/LO owner, stall source.
// Ports: start_i/op_i/rs_i/rt_i issue, rd_hilo_i MFHI/MFLO, flush_i squash;
//        stall_o, busy_o, done_o, divz_o status; hi_o/lo_o register outputs.
module exec_muldiv_ctrl
    import exec_muldiv_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] rs_i,
    input  logic [DATA_W-1:0] rt_i,
    input  logic              rd_hilo_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              divz_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int AW = 2 * DATA_W + 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [AW-1:0]       acc_q, acc_step;
    logic [DATA_W-1:0]   opnd_q;
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic                is_div_q, neg_lo_q, neg_hi_q, divz_q;

    logic                is_mul_op, is_div_op, sgn_op;
    logic                sign_a, sign_b;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic                go, go_calc, go_divz;

    logic [2*DATA_W-1:0] prod, prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;
    logic [DATA_W-1:0]   res_hi, res_lo;
    logic                unused_acc_top;

    // Issue decode
    always_comb begin
        is_mul_op = (op_i == OP_MULT) || (op_i == OP_MULTU);
        is_div_op = (op_i == OP_DIV) || (op_i == OP_DIVU);
        sgn_op    = is_signed_op(op_i);
        sign_a    = sgn_op & rs_i[DATA_W-1];
        sign_b    = sgn_op & rt_i[DATA_W-1];
        mag_a     = sign_a ? -rs_i : rs_i;
        mag_b     = sign_b ? -rt_i : rt_i;
        go        = start_i & ~flush_i & (state_q == ST_IDLE);
        go_calc   = go & (is_mul_op | (is_div_op & (rt_i != '0)));
        go_divz   = go & is_div_op & (rt_i == '0);
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (go_calc) begin
                    state_d = ST_CALC;
                end else if (go_divz) begin
                    state_d = ST_FIX;
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    muldiv_iter_core #(
        .DATA_W(DATA_W)
    ) u_core (
        .acc     (acc_q),
        .opnd    (opnd_q),
        .div_mode(is_div_q),
        .acc_next(acc_step)
    );

    // Sign fix-up of the magnitude result
    always_comb begin
        prod     = acc_q[2*DATA_W-1:0];
        prod_fix = neg_lo_q ? -prod : prod;
        quo_fix  = neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
        rem_fix  = neg_hi_q ? -acc_q[2*DATA_W-1:DATA_W]
                            : acc_q[2*DATA_W-1:DATA_W];
        if (is_div_q) begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end else begin
            res_hi = prod_fix[2*DATA_W-1:DATA_W];
            res_lo = prod_fix[DATA_W-1:0];
        end
    end

    // Remainder is always below the divisor, so the top acc bit is zero here.
    assign unused_acc_top = acc_q[AW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            divz_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (go_calc) begin
                        acc_q    <= {{(DATA_W+1){1'b0}}, mag_a};
                        opnd_q   <= mag_b;
                        cnt_q    <= CNT_W'(DATA_W - 1);
                        is_div_q <= is_div_op;
                        neg_lo_q <= sign_a ^ sign_b;
                        neg_hi_q <= is_div_op ? sign_a : (sign_a ^ sign_b);
                        divz_q   <= 1'b0;
                    end else if (go_divz) begin
                        divz_q   <= 1'b1;
                    end else if (go && (op_i == OP_MTHI)) begin
                        hi_q     <= rs_i;
                    end else if (go && (op_i == OP_MTLO)) begin
                        lo_q     <= rs_i;
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_step;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_FIX: begin
                    if (!flush_i && !divz_q) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign stall_o = busy_o & (start_i | rd_hilo_i);
    assign done_o  = (state_q == ST_FIX) & ~flush_i;
    assign divz_o  = done_o & divz_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_exec_muldiv_ctrl.sv
// Self-checking bench for exec_muldiv_ctrl: directed spec vectors plus
// random issue traffic checked every cycle against a countdown model.
module tb_exec_muldiv_ctrl;
    import exec_muldiv_ctrl_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start_i = 1'b0;
    logic [2:0]   op_i = 3'd0;
    logic [W-1:0] rs_i = '0;
    logic [W-1:0] rt_i = '0;
    logic         rd_hilo_i = 1'b0;
    logic         flush_i = 1'b0;
    logic         stall_o, busy_o, done_o, divz_o;
    logic [W-1:0] hi_o, lo_o;

    always #5 clk = ~clk;

    exec_muldiv_ctrl #(.DATA_W(W), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs_i     (rs_i),
        .rt_i     (rt_i),
        .rd_hilo_i(rd_hilo_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .divz_o   (divz_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference arithmetic, straight from the operation definitions.
    function automatic logic [63:0] ref_calc(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return ua * ub;
            OP_DIV: begin
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU:  return {32'(ua % ub), 32'(ua / ub)};
            default:  return 64'd0;
        endcase
    endfunction

    // Model: remaining busy cycles of the current operation plus pending result.
    int           m_left;
    bit           m_divz;
    logic [W-1:0] m_hi, m_lo, m_rhi, m_rlo;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_divz <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_rhi  <= '0;
            m_rlo  <= '0;
        end else if (m_left > 0) begin
            if (flush_i) begin
                m_left <= 0;
            end else begin
                if (m_left == 1 && !m_divz) begin
                    m_hi <= m_rhi;
                    m_lo <= m_rlo;
                end
                m_left <= m_left - 1;
            end
        end else if (start_i && !flush_i) begin
            case (op_i)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                    if ((op_i == OP_DIV || op_i == OP_DIVU) && rt_i == '0) begin
                        m_left <= 1;
                        m_divz <= 1'b1;
                    end else begin
                        m_left <= W + 1;
                        m_divz <= 1'b0;
                        {m_rhi, m_rlo} <= ref_calc(op_i, rs_i, rt_i);
                    end
                end
                OP_MTHI: m_hi <= rs_i;
                OP_MTLO: m_lo <= rs_i;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",  64'(busy_o), 64'(m_left > 0));
            check("done",  64'(done_o), 64'(m_left == 1 && !flush_i));
            check("divz",  64'(divz_o), 64'(m_left == 1 && !flush_i && m_divz));
            check("stall", 64'(stall_o),
                  64'(m_left > 0 && (start_i || rd_hilo_i)));
            check("hi", 64'(hi_o), 64'(m_hi));
            check("lo", 64'(lo_o), 64'(m_lo));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int stalls);
        start_i = 1'b1;
        op_i    = op;
        rs_i    = a;
        rt_i    = b;
        #1;
        stalls = 0;
        while (stall_o && stalls < 200) begin
            stalls++;
            tick();
        end
        if (stalls >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: stalled %0d cycles, limit 200", stalls);
        end
        tick();
        start_i = 1'b0;
    endtask

    // Issues one op and follows it until idle, recording timing of the pulses.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int busy_c,
                          output int done_cyc, output int done_c,
                          output int divz_c);
        int st, cyc;
        issue(op, a, b, st);
        cyc = 1;
        busy_c = 0;
        done_cyc = -1;
        done_c = 0;
        divz_c = 0;
        while (busy_o && cyc < 200) begin
            busy_c++;
            if (done_o) begin
                done_c++;
                done_cyc = cyc;
            end
            if (divz_o) divz_c++;
            cyc++;
            tick();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int bc, dcy, dc, zc, st, st2, n;

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);

        check("ref_mult",  ref_calc(OP_MULT, 32'hFFFF_FFFE, 32'd3),
              64'hFFFF_FFFF_FFFF_FFFA);
        check("ref_multu", ref_calc(OP_MULTU, 32'hFFFF_FFFE, 32'd3),
              64'h0000_0002_FFFF_FFFA);
        check("ref_divu",  ref_calc(OP_DIVU, 32'd100, 32'd7),
              64'h0000_0002_0000_000E);
        check("ref_div",   ref_calc(OP_DIV, 32'hFFFF_FFF9, 32'd2),
              64'hFFFF_FFFF_FFFF_FFFD);
        check("ref_ovf",   ref_calc(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF),
              64'h0000_0000_8000_0000);

        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, bc, dcy, dc, zc);
        check("mult_busy_cycles", 64'(bc), 64'd33);
        check("mult_done_cycle", 64'(dcy), 64'd33);
        check("mult_done_count", 64'(dc), 64'd1);
        check("mult_hi", 64'(hi_o), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo_o), 64'hFFFF_FFFA);

        run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, bc, dcy, dc, zc);
        check("multu_hi", 64'(hi_o), 64'h0000_0002);
        check("multu_lo", 64'(lo_o), 64'hFFFF_FFFA);

        run_op(OP_DIVU, 32'd100, 32'd7, bc, dcy, dc, zc);
        check("divu_lo", 64'(lo_o), 64'h0000_000E);
        check("divu_hi", 64'(hi_o), 64'h0000_0002);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, bc, dcy, dc, zc);
        check("div_lo", 64'(lo_o), 64'hFFFF_FFFD);
        check("div_hi", 64'(hi_o), 64'hFFFF_FFFF);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, dcy, dc, zc);
        check("ovf_lo", 64'(lo_o), 64'h8000_0000);
        check("ovf_hi", 64'(hi_o), 64'h0000_0000);

        run_op(OP_DIV, 32'd5, 32'd0, bc, dcy, dc, zc);
        check("divz_busy_cycles", 64'(bc), 64'd1);
        check("divz_done_cycle", 64'(dcy), 64'd1);
        check("divz_pulses", 64'(zc), 64'd1);
        check("divz_lo_kept", 64'(lo_o), 64'h8000_0000);
        check("divz_hi_kept", 64'(hi_o), 64'h0000_0000);

        issue(OP_MTHI, 32'h1234_5678, 32'd0, st);
        check("mthi_hi", 64'(hi_o), 64'h1234_5678);
        issue(OP_MTLO, 32'h9ABC_DEF0, 32'd0, st);
        check("mtlo_lo", 64'(lo_o), 64'h9ABC_DEF0);
        check("mtlo_hi", 64'(hi_o), 64'h1234_5678);

        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, st);
        tick();
        tick();
        rd_hilo_i = 1'b1;
        #1;
        n = 0;
        while (stall_o && n < 100) begin
            n++;
            tick();
        end
        rd_hilo_i = 1'b0;
        check("mfhi_stall_cycles", 64'(n), 64'd31);
        check("mfhi_value", 64'(hi_o), 64'hFFFF_FFFF);

        issue(OP_MULT, 32'd5, 32'd6, st);
        issue(OP_MULTU, 32'h10, 32'h20, st2);
        check("second_start_stalls", 64'(st2), 64'd33);
        n = 0;
        while (busy_o && n < 100) begin
            n++;
            tick();
        end
        check("b2b_lo", 64'(lo_o), 64'h0000_0200);
        check("b2b_hi", 64'(hi_o), 64'h0000_0000);

        issue(OP_DIVU, 32'd1000, 32'd3, st);
        repeat (9) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("flush_busy", 64'(busy_o), 64'd0);
        check("flush_lo_kept", 64'(lo_o), 64'h0000_0200);

        start_i = 1'b1;
        op_i = OP_MULT;
        flush_i = 1'b1;
        tick();
        start_i = 1'b0;
        flush_i = 1'b0;
        check("flush_start_ignored", 64'(busy_o), 64'd0);

        issue(OP_MULT, 32'd7, 32'd9, st);
        repeat (19) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_hi", 64'(hi_o), 64'd0);
        check("midrst_lo", 64'(lo_o), 64'd0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            start_i   = ($urandom % 3) == 0;
            op_i      = 3'($urandom % 8);
            rs_i      = pick();
            rt_i      = pick();
            rd_hilo_i = ($urandom % 4) == 0;
            flush_i   = ($urandom % 40) == 0;
            tick();
        end
        start_i = 1'b0;
        rd_hilo_i = 1'b0;
        flush_i = 1'b0;
        n = 0;
        while (busy_o && n < 100) begin
            n++;
            tick();
        end
        check("drain_idle", 64'(busy_o), 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
